// File: rtl/gzip_axis_pkg.sv
// Shared types and constants for the gzip AXI-Stream byte unpacker.
package gzip_axis_pkg;

  localparam int DEF_DATA_W     = 64;
  localparam int DEF_CNT_W      = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

  typedef enum logic {IDLE, DRAIN} state_t;

  typedef logic [DEF_CNT_W-1:0] byte_cnt_t;

endpackage

// File: rtl/gzip_axis_byte_unpacker_keep_decode.sv
// TKEEP decoder: byte count = highest set bit index + 1, and a hole-free flag.
module gzip_keep_decode
  import gzip_axis_pkg::*;
#(
  parameter int KEEP_W = BYTES_PER_WORD,
  parameter int N_W    = $clog2(KEEP_W) + 1
) (
  input  logic [KEEP_W-1:0] keep,
  output logic [N_W-1:0]    n,
  output logic              contiguous
);

  always_comb begin
    n = '0;
    for (int i = 0; i < KEEP_W; i++) begin
      if (keep[i]) n = N_W'(i + 1);
    end
  end

  // Any cleared bit below the top set bit is a hole.
  always_comb begin
    contiguous = 1'b1;
    for (int i = 0; i < KEEP_W; i++) begin
      if (!keep[i] && (i < int'(n))) contiguous = 1'b0;
    end
  end

endmodule

// File: rtl/gzip_axis_byte_unpacker.sv
// Serialises 64-bit AXIS words into an LSB-first byte stream with frame counting.
// Optional length check against TUSER: define GZIP_UNPACK_LEN_CHECK_EN.
module gzip_axis_byte_unpacker
  import gzip_axis_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  input  logic [DATA_W-1:0]   s_tdata,
  input  logic [DATA_W/8-1:0] s_tkeep,
  input  logic                s_tvalid,
  output logic                s_tready,
  input  logic                s_tlast,
  input  logic [CNT_W-1:0]    s_tuser,
  output logic [7:0]          m_tdata,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic [CNT_W-1:0]    frame_bytes,
  output logic                frame_done,
  output logic                err_keep
`ifdef GZIP_UNPACK_LEN_CHECK_EN
  ,
  output logic                err_len,
  output logic [31:0]         len_err_cnt
`endif
);

  localparam int BPW = DATA_W / 8;
  localparam int N_W = $clog2(BPW) + 1;

  state_t             state, state_next;
  logic [DATA_W-1:0]  hold;
  logic [N_W-1:0]     hold_n, idx, beat_n;
  logic               hold_last, beat_contig;
  logic [CNT_W-1:0]   run_cnt, run_cnt_inc, cnt_after;
  logic               last_byte, accept, load, zero_last, byte_hs, byte_end;

  gzip_keep_decode #(.KEEP_W(BPW), .N_W(N_W)) u_keep_decode (
    .keep       (s_tkeep),
    .n          (beat_n),
    .contiguous (beat_contig)
  );

  assign last_byte = (idx == hold_n - 1'b1);

  // Ready on the last byte's handshake lets the next word load with no bubble.
  always_comb begin
    state_next = state;
    s_tready   = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = '0;
    m_tlast    = 1'b0;
    case (state)
      IDLE: begin
        s_tready = !ap_rst;
        if (s_tvalid && (beat_n != '0)) state_next = DRAIN;
      end
      DRAIN: begin
        m_tvalid = 1'b1;
        m_tdata  = 8'(hold >> (8 * idx));
        m_tlast  = hold_last && last_byte;
        s_tready = m_tready && last_byte;
        if (m_tready && last_byte)
          state_next = (s_tvalid && (beat_n != '0)) ? DRAIN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept      = s_tvalid && s_tready;
  assign load        = accept && (beat_n != '0);
  assign zero_last   = accept && (beat_n == '0) && s_tlast;
  assign byte_hs     = m_tvalid && m_tready;
  assign byte_end    = byte_hs && m_tlast;
  assign run_cnt_inc = run_cnt + 1'b1;
  assign cnt_after   = byte_end ? '0 : (byte_hs ? run_cnt_inc : run_cnt);

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      hold      <= '0;
      hold_n    <= '0;
      hold_last <= 1'b0;
      idx       <= '0;
    end else if (load) begin
      hold      <= s_tdata;
      hold_n    <= beat_n;
      hold_last <= s_tlast;
      idx       <= '0;
    end else if (byte_hs) begin
      idx <= idx + 1'b1;
    end
  end

  // A zero-keep TLAST beat closes the frame with whatever was counted so far.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      run_cnt     <= '0;
      frame_bytes <= '0;
      frame_done  <= 1'b0;
      err_keep    <= 1'b0;
    end else begin
      run_cnt    <= zero_last ? '0 : cnt_after;
      frame_done <= zero_last || byte_end;
      if (zero_last)     frame_bytes <= cnt_after;
      else if (byte_end) frame_bytes <= run_cnt_inc;
      if (accept && (!beat_contig || zero_last)) err_keep <= 1'b1;
    end
  end

`ifdef GZIP_UNPACK_LEN_CHECK_EN
  logic [CNT_W-1:0] hold_user;
  logic             len_mismatch;

  always_comb begin
    len_mismatch = 1'b0;
    if (zero_last)     len_mismatch = (cnt_after != s_tuser);
    else if (byte_end) len_mismatch = (run_cnt_inc != hold_user);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      hold_user   <= '0;
      err_len     <= 1'b0;
      len_err_cnt <= '0;
    end else begin
      if (load) hold_user <= s_tuser;
      if (len_mismatch) begin
        err_len     <= 1'b1;
        len_err_cnt <= len_err_cnt + 1'b1;
      end
    end
  end
`else
  logic unused_tuser;
  assign unused_tuser = ^s_tuser;
`endif

endmodule

// File: tb/tb_gzip_axis_byte_unpacker.sv
// Directed self-checking bench for gzip_axis_byte_unpacker.
module tb_gzip_axis_byte_unpacker;

  logic        ap_clk;
  logic        ap_rst;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [31:0] s_tuser;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic [31:0] frame_bytes;
  logic        frame_done;
  logic        err_keep;
`ifdef GZIP_UNPACK_LEN_CHECK_EN
  logic        err_len;
  logic [31:0] len_err_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0]  byte_q[$];
  bit          last_q[$];
  int          cyc_q[$];
  logic [31:0] done_q[$];

  gzip_axis_byte_unpacker dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .s_tdata     (s_tdata),
    .s_tkeep     (s_tkeep),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .s_tlast     (s_tlast),
    .s_tuser     (s_tuser),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tlast     (m_tlast),
    .frame_bytes (frame_bytes),
    .frame_done  (frame_done),
`ifdef GZIP_UNPACK_LEN_CHECK_EN
    .err_len     (err_len),
    .len_err_cnt (len_err_cnt),
`endif
    .err_keep    (err_keep)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  always @(posedge ap_clk) cyc++;

  // Byte and frame capture, sampled mid-cycle.
  always @(negedge ap_clk) begin
    if (!ap_rst) begin
      if (m_tvalid && m_tready) begin
        byte_q.push_back(m_tdata);
        last_q.push_back(m_tlast);
        cyc_q.push_back(cyc);
      end
      if (frame_done) done_q.push_back(frame_bytes);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic clear_q();
    byte_q.delete();
    last_q.delete();
    cyc_q.delete();
    done_q.delete();
  endtask

  task automatic send_word(input logic [63:0] data, input logic [7:0] keep,
                           input logic last, input logic [31:0] user);
    int g = 0;
    s_tdata  = data;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tuser  = user;
    s_tvalid = 1'b1;
    do begin
      @(negedge ap_clk);
      g++;
    end while (!s_tready && g < 200);
    if (!s_tready) begin
      checks++; errors++;
      $display("[TB] FAIL send_word: s_tready=%0d after %0d cycles, required 1", s_tready, g);
    end
    @(posedge ap_clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_done(input int n);
    int g = 0;
    while (done_q.size() < n && g < 300) begin
      @(negedge ap_clk);
      g++;
    end
    if (done_q.size() < n) begin
      checks++; errors++;
      $display("[TB] FAIL wait_done: frame_done pulses=%0d, required %0d", done_q.size(), n);
    end
    repeat (3) @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge ap_clk); #1;
    ap_rst   = 1'b1;
    s_tvalid = 1'b0;
    @(posedge ap_clk); #1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    clear_q();
  endtask

  task automatic test_reset();
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    checks++; if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_tvalid: got %b required 0", m_tvalid); end
    checks++; if (m_tdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_m_tdata: got %h required 00", m_tdata); end
    checks++; if (m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_tlast: got %b required 0", m_tlast); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_s_tready: got %b required 0", s_tready); end
    checks++; if (frame_bytes !== 32'd0) begin errors++; $display("[TB] FAIL reset_frame_bytes: got %0d required 0", frame_bytes); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done: got %b required 0", frame_done); end
    checks++; if (err_keep !== 1'b0) begin errors++; $display("[TB] FAIL reset_err_keep: got %b required 0", err_keep); end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(posedge ap_clk); #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL idle_s_tready: got %b required 1", s_tready); end
    clear_q();
  endtask

  task automatic test_single_frame();
    bit bubble = 0;
    m_tready = 1'b1;
    clear_q();
    send_word(64'h0807060504030201, 8'hFF, 1'b0, 32'd0);
    send_word(64'h100F0E0D0C0B0A09, 8'hFF, 1'b0, 32'd0);
    send_word(64'hAAAAAAAAAA131211, 8'h07, 1'b1, 32'd0);
    wait_done(1);
    checks++; if (byte_q.size() != 19) begin errors++; $display("[TB] FAIL single_count: got %0d bytes required 19", byte_q.size()); end
    for (int k = 0; k < byte_q.size() && k < 19; k++) begin
      checks++;
      if (byte_q[k] !== 8'(k + 1) || last_q[k] !== (k == 18)) begin
        errors++;
        $display("[TB] FAIL single_byte[%0d]: got %h last=%0d required %h last=%0d", k, byte_q[k], last_q[k], 8'(k + 1), (k == 18));
      end
      if (k > 0 && cyc_q[k] != cyc_q[k-1] + 1) bubble = 1;
    end
    checks++; if (bubble) begin errors++; $display("[TB] FAIL single_bubble: gap between bytes, required none"); end
    checks++; if (done_q.size() != 1) begin errors++; $display("[TB] FAIL single_done_pulses: got %0d required 1", done_q.size()); end
    checks++; if (frame_bytes !== 32'd19) begin errors++; $display("[TB] FAIL single_frame_bytes: got %0d required 19", frame_bytes); end
  endtask

  task automatic test_backpressure();
    int pat[4] = '{1, 0, 0, 1};
    int hs = 0;
    int k = 0;
    clear_q();
    m_tready = 1'b1;
    @(posedge ap_clk); #1;
    fork
      begin
        send_word(64'h3736353433323130, 8'hFF, 1'b0, 32'd0);
        send_word(64'hFFFFFFFFFFFF3938, 8'h03, 1'b1, 32'd0);
      end
      begin
        while (hs < 10 && k < 200) begin
          @(posedge ap_clk); #1;
          m_tready = (pat[k % 4] != 0);
          k++;
          @(negedge ap_clk);
          if (m_tvalid) begin
            logic [7:0] exp_d;
            logic       exp_rdy;
            exp_d   = 8'h30 + 8'(hs);
            exp_rdy = m_tready && (hs == 7 || hs == 9);
            checks++;
            if (m_tdata !== exp_d || m_tlast !== (hs == 9)) begin
              errors++;
              $display("[TB] FAIL bp_byte[%0d]: got %h last=%0d required %h last=%0d", hs, m_tdata, m_tlast, exp_d, (hs == 9));
            end
            checks++;
            if (s_tready !== exp_rdy) begin
              errors++;
              $display("[TB] FAIL bp_s_tready[%0d]: got %b required %b", hs, s_tready, exp_rdy);
            end
            if (m_tready) hs++;
          end
        end
        if (hs < 10) begin
          checks++; errors++;
          $display("[TB] FAIL bp_timeout: got %0d bytes required 10", hs);
        end
      end
    join
    m_tready = 1'b1;
    wait_done(1);
    checks++; if (frame_bytes !== 32'd10) begin errors++; $display("[TB] FAIL bp_frame_bytes: got %0d required 10", frame_bytes); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[12] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h51, 8'h52, 8'h53, 8'h54,
                              8'h55, 8'h56, 8'h57, 8'h58};
    m_tready = 1'b1;
    clear_q();
    send_word(64'hEEEEEEEE44434241, 8'h0F, 1'b1, 32'd0);
    send_word(64'h5857565554535251, 8'hFF, 1'b1, 32'd0);
    wait_done(2);
    checks++; if (done_q.size() != 2) begin errors++; $display("[TB] FAIL b2b_done_pulses: got %0d required 2", done_q.size()); end
    if (done_q.size() >= 2) begin
      checks++; if (done_q[0] !== 32'd4) begin errors++; $display("[TB] FAIL b2b_frame_a: got %0d required 4", done_q[0]); end
      checks++; if (done_q[1] !== 32'd8) begin errors++; $display("[TB] FAIL b2b_frame_b: got %0d required 8", done_q[1]); end
    end
    checks++; if (byte_q.size() != 12) begin errors++; $display("[TB] FAIL b2b_count: got %0d required 12", byte_q.size()); end
    for (int i = 0; i < byte_q.size() && i < 12; i++) begin
      checks++;
      if (byte_q[i] !== exp_b[i] || last_q[i] !== (i == 3 || i == 11)) begin
        errors++;
        $display("[TB] FAIL b2b_byte[%0d]: got %h last=%0d required %h last=%0d", i, byte_q[i], last_q[i], exp_b[i], (i == 3 || i == 11));
      end
    end
    checks++; if (err_keep !== 1'b0) begin errors++; $display("[TB] FAIL b2b_err_keep: got %b required 0", err_keep); end
  endtask

  task automatic test_malformed_keep();
    m_tready = 1'b1;
    clear_q();
    send_word(64'h0000000000CCBBAA, 8'h05, 1'b1, 32'd0);
    wait_done(1);
    checks++; if (byte_q.size() != 3) begin errors++; $display("[TB] FAIL hole_count: got %0d required 3", byte_q.size()); end
    if (byte_q.size() == 3) begin
      checks++;
      if (byte_q[0] !== 8'hAA || byte_q[1] !== 8'hBB || byte_q[2] !== 8'hCC) begin
        errors++; $display("[TB] FAIL hole_bytes: got %h %h %h required aa bb cc", byte_q[0], byte_q[1], byte_q[2]);
      end
    end
    checks++; if (err_keep !== 1'b1) begin errors++; $display("[TB] FAIL hole_err_keep: got %b required 1", err_keep); end
    checks++; if (frame_bytes !== 32'd3) begin errors++; $display("[TB] FAIL hole_frame_bytes: got %0d required 3", frame_bytes); end

    do_reset();
    checks++; if (err_keep !== 1'b0) begin errors++; $display("[TB] FAIL err_keep_cleared: got %b required 0", err_keep); end
    send_word(64'h1111111111111111, 8'h00, 1'b0, 32'd0);
    repeat (3) @(posedge ap_clk);
    #1;
    checks++;
    if (err_keep !== 1'b0 || byte_q.size() != 0 || done_q.size() != 0) begin
      errors++; $display("[TB] FAIL zero_keep_drop: err_keep=%b bytes=%0d dones=%0d required 0 0 0", err_keep, byte_q.size(), done_q.size());
    end
    send_word(64'h0000000000005A4B, 8'h03, 1'b0, 32'd0);
    send_word(64'h0000000000000000, 8'h00, 1'b1, 32'd0);
    wait_done(1);
    checks++; if (done_q.size() != 1) begin errors++; $display("[TB] FAIL zero_last_pulses: got %0d required 1", done_q.size()); end
    checks++; if (frame_bytes !== 32'd2) begin errors++; $display("[TB] FAIL zero_last_bytes: got %0d required 2", frame_bytes); end
    checks++; if (err_keep !== 1'b1) begin errors++; $display("[TB] FAIL zero_last_err_keep: got %b required 1", err_keep); end
    checks++;
    if (byte_q.size() != 2 || last_q.size() != 2 || last_q[0] || last_q[1]) begin
      errors++; $display("[TB] FAIL zero_last_stream: got %0d bytes required 2 bytes without m_tlast", byte_q.size());
    end
  endtask

  task automatic test_reset_mid_drain();
    int g = 0;
    do_reset();
    m_tready = 1'b1;
    send_word(64'h6766656463626160, 8'hFF, 1'b1, 32'd0);
    while (byte_q.size() < 4 && g < 50) begin
      @(negedge ap_clk); #1;
      g++;
    end
    checks++; if (byte_q.size() != 4) begin errors++; $display("[TB] FAIL mid_reach_idx3: got %0d bytes required 4", byte_q.size()); end
    ap_rst = 1'b1;
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 8'h00 || m_tlast !== 1'b0 || s_tready !== 1'b0 ||
        frame_bytes !== 32'd0 || frame_done !== 1'b0 || err_keep !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got valid=%b data=%h last=%b rdy=%b fb=%0d done=%b ek=%b required all 0",
               m_tvalid, m_tdata, m_tlast, s_tready, frame_bytes, frame_done, err_keep);
    end
    @(negedge ap_clk);
    ap_rst = 1'b0;
    clear_q();
    repeat (4) @(posedge ap_clk);
    #1;
    checks++; if (done_q.size() != 0 || byte_q.size() != 0) begin errors++; $display("[TB] FAIL mid_no_done: dones=%0d bytes=%0d required 0 0", done_q.size(), byte_q.size()); end
    send_word(64'hFFFF757473727170, 8'h3F, 1'b1, 32'd0);
    wait_done(1);
    checks++; if (frame_bytes !== 32'd6) begin errors++; $display("[TB] FAIL mid_next_frame: got %0d required 6", frame_bytes); end
    checks++;
    if (byte_q.size() != 6 || byte_q[0] !== 8'h70 || byte_q[5] !== 8'h75 || !last_q[5]) begin
      errors++; $display("[TB] FAIL mid_next_bytes: got %0d bytes required 6 (70..75, last on 75)", byte_q.size());
    end
  endtask

`ifdef GZIP_UNPACK_LEN_CHECK_EN
  task automatic test_len_check();
    do_reset();
    m_tready = 1'b1;
    send_word(64'h0807060504030201, 8'hFF, 1'b0, 32'd0);
    send_word(64'h000000000C0B0A09, 8'h0F, 1'b1, 32'd12);
    wait_done(1);
    checks++; if (frame_bytes !== 32'd12) begin errors++; $display("[TB] FAIL len_frame_bytes: got %0d required 12", frame_bytes); end
    checks++; if (err_len !== 1'b0) begin errors++; $display("[TB] FAIL len_match_err: got %b required 0", err_len); end
    checks++; if (len_err_cnt !== 32'd0) begin errors++; $display("[TB] FAIL len_match_cnt: got %0d required 0", len_err_cnt); end
    send_word(64'h0807060504030201, 8'hFF, 1'b0, 32'd0);
    send_word(64'h000000000C0B0A09, 8'h0F, 1'b1, 32'd13);
    wait_done(2);
    checks++; if (err_len !== 1'b1) begin errors++; $display("[TB] FAIL len_mismatch_err: got %b required 1", err_len); end
    checks++; if (len_err_cnt !== 32'd1) begin errors++; $display("[TB] FAIL len_mismatch_cnt: got %0d required 1", len_err_cnt); end
  endtask
`endif

  initial begin
    ap_rst   = 1'b1;
    s_tdata  = '0;
    s_tkeep  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
    m_tready = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_malformed_keep();
    test_reset_mid_drain();
`ifdef GZIP_UNPACK_LEN_CHECK_EN
    test_len_check();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gzip_axis_byte_unpacker.md
Name: gzip_axis_byte_unpacker

Overview:
- Downstream neighbour of the gzip core. Consumes the core's 64-bit AXI-Stream compressed output (TDATA/TKEEP/TLAST/TUSER) and serialises it into an 8-bit byte stream, least-significant byte first.
- Counts the bytes in each frame and flags malformed TKEEP.
- Feeds the byte-wide file/DMA writer, which needs one byte per beat.

Parameters:
- DATA_W, 64: input TDATA width in bits. Must be a multiple of 8, max 64.
- CNT_W, 32: width of the frame byte counter and of TUSER.

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- s_tdata  in  DATA_W  input word.
- s_tkeep  in  DATA_W/8  byte enables, expected contiguous from bit 0.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- s_tlast  in  1  last word of frame.
- s_tuser  in  CNT_W  compressed frame length from the core. Only meaningful with the optional feature.
- m_tdata  out  8  output byte.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tlast  out  1  last byte of frame.
- frame_bytes  out  CNT_W  byte count of the most recently completed frame.
- frame_done  out  1  one-cycle pulse when a frame completes.
- err_keep  out  1  sticky: non-contiguous TKEEP seen, or a zero-TKEEP beat with TLAST seen.

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, holding register 0, byte counters 0, error flags 0.
- Per-beat byte count n = index of the highest set TKEEP bit + 1 (0 if TKEEP == 0). Holes below the top bit are still emitted and set err_keep.
- FSM IDLE:
  - s_tready = 1.
  - On s_tvalid && n > 0: latch data, n, tlast, tuser; idx = 0; go to DRAIN.
  - On s_tvalid && n == 0 && !s_tlast: drop the beat silently.
  - On s_tvalid && n == 0 && s_tlast: drop the beat, set err_keep, pulse frame_done with frame_bytes = running count (no m_tlast is possible), clear the running count.
- FSM DRAIN:
  - m_tvalid = 1; m_tdata = hold[8*idx +: 8]; m_tlast = hold_last && (idx == n-1).
  - On m_tready: idx++ and running count +1 (wraps at 2^CNT_W, no saturation).
  - s_tready = m_tready && (idx == n-1), combinational, giving back-to-back words with no bubble. A word accepted in the same cycle reloads the holding register and stays in DRAIN. Otherwise the last byte handshake returns to IDLE.
- Latency: word accepted in cycle t; its first byte is valid in t+1. Sustained rate is 1 byte/cycle.
- m_tdata, m_tvalid and m_tlast stay stable while m_tvalid && !m_tready (AXIS rule).
- Frame end: on the handshake of the byte with m_tlast:
  - frame_bytes <= running count + 1;
  - frame_done pulses the next cycle;
  - running count clears to 0.
  - If a new frame's first word is accepted the same cycle, its bytes count from 0.
- Reset mid-frame: the holding register is discarded and the partial frame is lost. No frame_done is produced.
- err_keep clears only on ap_rst.

Optional Feature:
- Macro: GZIP_UNPACK_LEN_CHECK_EN.
- When defined:
  - Adds output port err_len (1 bit, sticky).
  - At frame end, compares the completed byte count with the s_tuser value latched from the TLAST beat; on mismatch, sets err_len.
  - Also adds the 32-bit mismatch-count register len_err_cnt, exposed as output len_err_cnt.
- When undefined:
  - Neither port exists and s_tuser is ignored.
  - All other behaviour is identical.

Decomposition:
- Shared package gzip_axis_pkg holds: DATA_W/8 bytes-per-word constant; the FSM state enum {IDLE, DRAIN}; the byte-count type logic [CNT_W-1:0].
- One sub-module, gzip_keep_decode (combinational):
  - input: TKEEP;
  - outputs: n (clog2(DATA_W/8)+1 bits) and contiguous flag;
  - instantiated once on s_tkeep.

Test Plan:
- Single frame: 3 words, TKEEP FF, FF, 07, m_tready = 1 -> 19 bytes in LSB-first order; m_tlast on byte 19 only; frame_bytes = 19; one frame_done pulse; no bubble between words.
- Backpressure: m_tready toggles 1, 0, 0, 1 across a 2-word frame -> m_tdata stable while stalled; s_tready = 0 until the last byte of each word is handshaken.
- Back-to-back frames: frame A (1 word, TKEEP 0F, TLAST) followed immediately by frame B (TKEEP FF, TLAST) -> frame_bytes = 4 then 8; running count restarts at 0.
- Malformed keep: TKEEP 0x05 -> 3 bytes emitted, err_keep = 1. Separately, a zero-TKEEP TLAST beat -> frame_done pulses, err_keep = 1.
- Reset mid-DRAIN: assert ap_rst while idx = 3 -> all outputs 0 immediately; the next frame is counted from 0.
- GZIP_UNPACK_LEN_CHECK_EN: 12-byte frame with s_tuser = 12 -> err_len stays 0. Then a 12-byte frame with s_tuser = 13 -> err_len = 1, len_err_cnt = 1.
